// File: rtl/dmem_access_sequencer_if.sv
// Bundle of the requester handshake, the completion pulse and the byte-wide
// memory port of dmem_access_sequencer.
//
// Handshake: a request on port r transfers when req_valid[r] && req_ready[r]
// are both high at a rising clock edge. req_ready is one-hot and is only
// raised while the sequencer is idle. The completion pulse rsp_valid[r] is
// high for exactly one cycle and cannot be stalled by the requester.
interface dmem_access_sequencer_if #(
   parameter int XLEN      = 32,
   parameter int BYTE_SIZE = 8
);
   logic [1:0]                 req_valid;
   logic [1:0]                 req_ready;
   logic [1:0]                 req_write;
   logic [1:0][2:0]            req_funct3;
   logic [1:0][XLEN-1:0]       req_addr;
   logic [1:0][XLEN-1:0]       req_wdata;
   logic [1:0]                 rsp_valid;
   logic                       rsp_error;
   logic [XLEN-1:0]            rsp_rdata;
   logic                       mem_read_enable;
   logic                       mem_write_enable;
   logic [XLEN-1:0]            mem_addr;
   logic [BYTE_SIZE-1:0]       mem_write_data;
   logic [BYTE_SIZE-1:0]       mem_read_data;

   // Sequencer side
   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
      output req_ready, rsp_valid, rsp_error, rsp_rdata,
             mem_read_enable, mem_write_enable, mem_addr, mem_write_data
   );

   // Requester / memory side
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
      input  req_ready, rsp_valid, rsp_error, rsp_rdata,
             mem_read_enable, mem_write_enable, mem_addr, mem_write_data
   );
endinterface

// File: rtl/dmem_access_sequencer.sv
// dmem_access_sequencer: arbitrates two requesters (0 = core, 1 = loader)
// onto a byte-wide data memory and splits each access into 1, 2 or 4 byte
// beats, reassembling and extending load data.
// Optional build macro: MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses complete immediately with rsp_error instead of
// executing byte-serially.
module dmem_access_sequencer #(
   parameter int XLEN      = 32,
   parameter int BYTE_SIZE = 8,
   parameter int MEM_STEPS = XLEN / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   dmem_access_sequencer_if.slave bus,
   output logic [1:0]            dbg_state
);
   localparam int KW = $clog2(MEM_STEPS);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;     // port that wins a tie
   logic              r_q, r_d;           // requester being served
   logic              write_q, write_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [KW-1:0]     k_q, k_d;           // beat index
   logic [XLEN-1:0]   rbuf_q, rbuf_d;     // load reassembly buffer
   logic              err_q, err_d;
   logic              gnt;
   logic              mis;

   // Index of the final beat for a size code (byte, half, word).
   function automatic logic [KW-1:0] last_beat(input logic [1:0] size);
      case (size)
         2'b00:   last_beat = '0;
         2'b01:   last_beat = KW'(1);
         default: last_beat = KW'(MEM_STEPS - 1);
      endcase
   endfunction

   // Reserved size codes, and unsigned variants used with a store.
   function automatic logic is_illegal(input logic [2:0] f3, input logic wr);
      is_illegal = (f3 == 3'b011) || (f3[2] && f3[1]) || (wr && f3[2]);
   endfunction

   // Sign/zero extension of the reassembled load bytes.
   function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] b);
      case (f3)
         3'b000:  extend = {{(XLEN-BYTE_SIZE){b[BYTE_SIZE-1]}}, b[BYTE_SIZE-1:0]};
         3'b001:  extend = {{(XLEN-2*BYTE_SIZE){b[2*BYTE_SIZE-1]}}, b[2*BYTE_SIZE-1:0]};
         3'b100:  extend = {{(XLEN-BYTE_SIZE){1'b0}}, b[BYTE_SIZE-1:0]};
         3'b101:  extend = {{(XLEN-2*BYTE_SIZE){1'b0}}, b[2*BYTE_SIZE-1:0]};
         3'b010:  extend = b;
         default: extend = '0;
      endcase
   endfunction

   assign dbg_state = state_q;

   // Next-state, grant, beat generation and response formatting.
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      r_d      = r_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      k_d      = k_q;
      rbuf_d   = rbuf_q;
      err_d    = err_q;
      gnt      = 1'b0;
      mis      = 1'b0;
      bus.req_ready        = '0;
      bus.rsp_valid        = '0;
      bus.rsp_error        = 1'b0;
      bus.rsp_rdata        = '0;
      bus.mem_read_enable  = 1'b0;
      bus.mem_write_enable = 1'b0;
      bus.mem_addr         = '0;
      bus.mem_write_data   = '0;
      case (state_q)
         IDLE: begin
            if (!rst && (bus.req_valid != 2'b00)) begin
               gnt = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
`ifdef MISALIGN_TRAP_EN
               mis = ((bus.req_funct3[gnt][1:0] == 2'b01) && bus.req_addr[gnt][0]) ||
                     ((bus.req_funct3[gnt][1:0] == 2'b10) && (bus.req_addr[gnt][1:0] != 2'b00));
`else
               mis = 1'b0;
`endif
               bus.req_ready[gnt] = 1'b1;
               prio_d   = ~gnt;
               r_d      = gnt;
               write_d  = bus.req_write[gnt];
               funct3_d = bus.req_funct3[gnt];
               addr_d   = bus.req_addr[gnt];
               wdata_d  = bus.req_wdata[gnt];
               k_d      = '0;
               rbuf_d   = '0;
               err_d    = is_illegal(bus.req_funct3[gnt], bus.req_write[gnt]) || mis;
               state_d  = err_d ? RESP : XFER;
            end
         end
         XFER: begin
            bus.mem_addr         = addr_q + XLEN'(k_q);
            bus.mem_write_enable = write_q;
            bus.mem_read_enable  = ~write_q;
            if (write_q)
               bus.mem_write_data = wdata_q[int'(k_q)*BYTE_SIZE +: BYTE_SIZE];
            else
               rbuf_d[int'(k_q)*BYTE_SIZE +: BYTE_SIZE] = bus.mem_read_data;
            if (k_q == last_beat(funct3_q[1:0]))
               state_d = RESP;
            else
               k_d = k_q + KW'(1);
         end
         RESP: begin
            bus.rsp_valid[r_q] = 1'b1;
            bus.rsp_error      = err_q;
            if (!write_q && !err_q)
               bus.rsp_rdata = extend(funct3_q, rbuf_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and request-context registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         r_q      <= 1'b0;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         k_q      <= '0;
         rbuf_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         r_q      <= r_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         k_q      <= k_d;
         rbuf_q   <= rbuf_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed bench for dmem_access_sequencer with a byte memory model.
module tb_dmem_access_sequencer;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_vec;
   int         n_miss;
   logic [31:0] exp_q[$];     // expected beat addresses
   logic [7:0]  exp_b_q[$];   // expected store bytes
   logic [7:0]  mem [0:4095];

   dmem_access_sequencer_if #(.XLEN(32), .BYTE_SIZE(8)) bus ();

   dmem_access_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   // byte memory: combinational read, write on rising edge
   assign bus.mem_read_data = mem[bus.mem_addr[11:0]];
   always @(posedge clk)
      if (bus.mem_write_enable) mem[bus.mem_addr[11:0]] <= bus.mem_write_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
      bus.req_write[p]  = w;
      bus.req_funct3[p] = f3;
      bus.req_addr[p]   = a;
      bus.req_wdata[p]  = wd;
   endtask

   // One access; expected beats must be queued in exp_q / exp_b_q first.
   task automatic run_access(input string tag, input int p, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      int nb;
      int exp_nb;
      logic got;
      exp_nb = exp_q.size();
      @(negedge clk);
      set_port(p, w, f3, a, wd);
      bus.req_valid = (p == 0) ? 2'b01 : 2'b10;
      #1 chk({tag, "_ready"}, 32'(bus.req_ready), (p == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 2'b00;
      lat = 0;
      nb  = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         #1;
         lat++;
         if (bus.mem_read_enable || bus.mem_write_enable) begin
            nb++;
            chk({tag, "_we"}, 32'(bus.mem_write_enable), 32'(w));
            chk({tag, "_re"}, 32'(bus.mem_read_enable), 32'(!w));
            chk({tag, "_beat_lat"}, lat, nb);
            if (exp_q.size() != 0) chk({tag, "_addr"}, bus.mem_addr, exp_q.pop_front());
            if (w && exp_b_q.size() != 0) chk({tag, "_wbyte"}, 32'(bus.mem_write_data), 32'(exp_b_q.pop_front()));
         end
         if (bus.rsp_valid != 2'b00) begin
            got = 1'b1;
            chk({tag, "_rsp_port"}, 32'(bus.rsp_valid), (p == 0) ? 32'd1 : 32'd2);
            chk({tag, "_rsp_err"}, 32'(bus.rsp_error), 32'(exp_err));
            chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
            chk({tag, "_rsp_lat"}, lat, exp_lat);
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
      chk({tag, "_beats"}, nb, exp_nb);
      exp_q.delete();
      exp_b_q.delete();
   endtask

   initial begin
      int n_rsp;
      int cyc;
      int last;
      logic seen;
      n_vec  = 0;
      n_miss = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      bus.req_valid  = '0;
      bus.req_write  = '0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      bus.req_valid = 2'b11;
      #1 chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rst_en", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
      bus.req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("idle_state", 32'(dbg_state), 32'd0);
      chk("idle_addr", bus.mem_addr, 32'd0);

      // aligned store / load
      exp_q   = '{32'h100, 32'h101, 32'h102, 32'h103};
      exp_b_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_access("sw", 0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5, 1'b0, 32'h0);
      exp_q = '{32'h100, 32'h101, 32'h102, 32'h103};
      run_access("lw", 0, 1'b0, 3'b010, 32'h100, 32'h0, 5, 1'b0, 32'hDEADBEEF);

      // sign / zero extension
      mem[12'h200] = 8'h80;
      mem[12'h201] = 8'hFF;
      exp_q = '{32'h200};
      run_access("lb", 0, 1'b0, 3'b000, 32'h200, 32'h0, 2, 1'b0, 32'hFFFFFF80);
      exp_q = '{32'h200};
      run_access("lbu", 0, 1'b0, 3'b100, 32'h200, 32'h0, 2, 1'b0, 32'h00000080);
      exp_q = '{32'h200, 32'h201};
      run_access("lh", 0, 1'b0, 3'b001, 32'h200, 32'h0, 3, 1'b0, 32'hFFFFFF80);
      exp_q = '{32'h200, 32'h201};
      run_access("lhu", 1, 1'b0, 3'b101, 32'h200, 32'h0, 3, 1'b0, 32'h0000FF80);

      // illegal size codes
      run_access("f3_011", 0, 1'b0, 3'b011, 32'h200, 32'h0, 1, 1'b1, 32'h0);
      run_access("sb_100", 1, 1'b1, 3'b100, 32'h200, 32'h55, 1, 1'b1, 32'h0);

      // misaligned word
      mem[12'h104] = 8'h11;
      mem[12'h105] = 8'h22;
`ifdef MISALIGN_TRAP_EN
      run_access("lw_mis", 0, 1'b0, 3'b010, 32'h102, 32'h0, 1, 1'b1, 32'h0);
`else
      exp_q = '{32'h102, 32'h103, 32'h104, 32'h105};
      run_access("lw_mis", 0, 1'b0, 3'b010, 32'h102, 32'h0, 5, 1'b0, 32'h2211DEAD);
`endif

      // port 1 back-to-back LH: one completion every 4 cycles
      @(negedge clk);
      set_port(1, 1'b0, 3'b001, 32'h200, 32'h0);
      bus.req_valid = 2'b10;
      n_rsp = 0; cyc = 0; last = 0;
      while (n_rsp < 3 && cyc < 40) begin
         #1 cyc++;
         if (bus.rsp_valid != 2'b00) begin
            chk("b2b_port", 32'(bus.rsp_valid), 32'd2);
            chk("b2b_rdata", bus.rsp_rdata, 32'hFFFFFF80);
            if (n_rsp > 0) chk("b2b_gap", cyc - last, 4);
            last = cyc;
            n_rsp++;
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      chk("b2b_count", n_rsp, 3);

      // reset while the third byte of a store is on the bus
      @(negedge clk);
      set_port(0, 1'b1, 3'b010, 32'h300, 32'h44332211);
      bus.req_valid = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 2'b00;
      repeat (2) @(negedge clk);
      #1 chk("rst_mid_addr_pre", bus.mem_addr, 32'h302);
      rst = 1'b1;
      #1 chk("rst_mid_en", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
      chk("rst_mid_addr", bus.mem_addr, 32'd0);
      chk("rst_mid_wdata", 32'(bus.mem_write_data), 32'd0);
      chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rst_mid_state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1 seen = seen | (bus.rsp_valid != 2'b00);
      end
      chk("rst_mid_no_rsp", 32'(seen), 32'd0);
      chk("rst_mem_300", 32'(mem[12'h300]), 32'h11);
      chk("rst_mem_301", 32'(mem[12'h301]), 32'h22);
      chk("rst_mem_302", 32'(mem[12'h302]), 32'h00);
      chk("rst_mem_303", 32'(mem[12'h303]), 32'h00);

      // tie after reset: grants alternate starting at port 0
      @(negedge clk);
      set_port(0, 1'b0, 3'b000, 32'h200, 32'h0);
      set_port(1, 1'b0, 3'b100, 32'h201, 32'h0);
      bus.req_valid = 2'b11;
      #1 chk("arb_first_grant", 32'(bus.req_ready), 32'd1);
      n_rsp = 0; cyc = 0; last = 0;
      while (n_rsp < 4 && cyc < 40) begin
         if (cyc > 0) #1;
         cyc++;
         if (bus.rsp_valid != 2'b00) begin
            chk("arb_port", 32'(bus.rsp_valid), (n_rsp % 2 == 0) ? 32'd1 : 32'd2);
            chk("arb_rdata", bus.rsp_rdata, (n_rsp % 2 == 0) ? 32'hFFFFFF80 : 32'h000000FF);
            if (n_rsp > 0) chk("arb_gap", cyc - last, 3);
            last = cyc;
            n_rsp++;
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      chk("arb_count", n_rsp, 4);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/dmem_access_sequencer.md
# dmem_access_sequencer

Sequences and arbitrates all accesses to the byte-wide data memory. Two requesters share the single memory port: the core load/store path (port 0) and the program loader (port 1). Each accepted LB/LH/LW/LBU/LHU/SB/SH/SW request is broken into 1, 2 or 4 single-byte memory beats. For loads, the bytes are reassembled and sign- or zero-extended into an XLEN response.

## Interface
- XLEN, 32, data and address width
- BYTE_SIZE, 8, memory word width (one beat)
- MEM_STEPS, 4, maximum beats per access (XLEN/BYTE_SIZE)

Ports (r = requester index, 0 = core, 1 = loader):

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  [1:0]  request pending per requester
- req_ready  out  [1:0]  one-hot grant; request accepted when valid&ready
- req_write  in  [1:0]  1 = store, 0 = load
- req_funct3  in  [1:0][2:0]  RISC-V funct3 size/sign code
- req_addr  in  [1:0][XLEN-1:0]  byte address
- req_wdata  in  [1:0][XLEN-1:0]  store data, byte k = bits [8k+7:8k]
- rsp_valid  out  [1:0]  one-hot, one-cycle completion pulse
- rsp_error  out  1  completion carried an error, no memory touched
- rsp_rdata  out  [XLEN-1:0]  load result (0 for stores/errors)
- mem_read_enable  out  1  read beat this cycle
- mem_write_enable  out  1  write beat this cycle
- mem_addr  out  [XLEN-1:0]  byte address of current beat
- mem_write_data  out  [BYTE_SIZE-1:0]  byte written this beat
- mem_read_data  in  [BYTE_SIZE-1:0]  combinational read return, same cycle

## Operation
- FSM states: IDLE, XFER, RESP.
- **IDLE**
  - req_ready is combinational and is asserted only in this state.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins (round-robin pointer). After reset, port 0 wins the first tie.
  - On acceptance, latch the requester index, write flag, funct3, address and wdata; clear the beat counter k and the read buffer.
  - Go to XFER, or to RESP with error set (see below).
- **Beat count n from funct3**
  - 000/100 → 1 beat.
  - 001/101 → 2 beats.
  - 010 → 4 beats.
  - funct3 011/110/111, or 100/101 combined with write → error.
- **XFER** (one beat per cycle)
  - mem_addr = addr + k, modulo 2^XLEN (wraps).
  - Exactly one of the enables is high.
  - Store: mem_write_data = wdata byte k.
  - Load: mem_read_data is captured into buffer byte k at the clock edge.
  - When k = n-1, go to RESP; otherwise k increments.
- **RESP**
  - rsp_valid[latched r] = 1 for one cycle, then return to IDLE.
  - Loads: funct3 000/001 sign-extend from bit 8n-1; 100/101 zero-extend; 010 passes the word through.
  - Requesters must accept the response; there is no backpressure.
- **Idle outputs:** enables, mem_addr, mem_write_data, rsp_* and req_ready (when not granting) are all 0.
- **Reset** (asynchronous, mid-operation allowed): state → IDLE, round-robin pointer → port 0, all outputs 0.
  - The aborted access gets no response.
  - Store bytes already written remain in memory.

## Timing
- Request accepted at edge T. Beats occur in cycles T+1 … T+n. rsp_valid is high in cycle T+n+1.
- Next grant possible in cycle T+n+2. Throughput is one access per n+2 cycles.
- Error requests: rsp_valid in cycle T+1, with no memory enables.
- req_valid is sampled only in IDLE. A requester may keep a request asserted through another requester's transaction.

## Configuration
- MISALIGN_TRAP_EN is the compile-time switch for misaligned accesses.
- **Defined:** a halfword with addr[0] ≠ 0, or a word with addr[1:0] ≠ 0, is an error.
  - Goes directly to RESP with rsp_error = 1 and no beats.
- **Undefined:** misaligned accesses execute byte-serially like aligned ones, with no error.
  - Address increments across the word boundary.

## Test plan
- **Aligned store/load:** port 0 SW addr 0x100 data 0xDEADBEEF → write beats at 0x100..0x103 with bytes EF, BE, AD, DE in cycles T+1..T+4. A following LW at 0x100 → rsp_rdata 0xDEADBEEF in cycle T+5.
- **Sign/zero extension:** memory byte 0x80 at 0x200. LB → 0xFFFFFF80; LBU → 0x00000080. LH at 0x200 over bytes 80,FF → 0xFFFF_FF80. Each responds at T+2 or T+3 as per n.
- **Arbitration:** both ports valid every cycle → grants alternate 0,1,0,1. Single-requester traffic from port 1 is granted back-to-back every n+2 cycles.
- **Misaligned:** LW at 0x102.
  - With MISALIGN_TRAP_EN: rsp_valid and rsp_error at T+1, no enables.
  - Without it: reads at 0x102..0x105 and a normal response.
- **Illegal funct3:** funct3 011, and SB-with-funct3 100 → rsp_error at T+1, rsp_rdata 0, no enables.
- **Reset mid-store:** assert rst during beat 2 of a SW → all outputs 0 immediately, no rsp_valid. The first two bytes are written and the last two are unchanged. After release, a port-0/port-1 tie grants port 0.
